// File: rtl/main_memory_ctrl.sv
// Backing main memory and controller behind the cache: serves 4-word block refills
// and absorbs write-through single-word stores. All state updates on the falling clock edge.
module main_memory_ctrl #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int RD_LAT    = 2,
    parameter int WR_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              main_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rd_valid,
    output logic [1:0]        rd_word,
    output logic              ready,
    output logic              wr_done,
    output logic              busy
);

    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_WAIT  = 3'd1,
        ST_RD_BURST = 3'd2,
        ST_RD_DONE  = 3'd3,
        ST_WRITE    = 3'd4
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_beat;
    logic [ADDR_W-1:0] r_addr_q;
    logic [DATA_W-1:0] r_data_q;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rd_valid;
    logic [1:0]        r_rd_word;
    logic              r_ready;
    logic              r_wr_done;
    logic              r_busy;

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

    state_t            w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [1:0]        w_beat_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [DATA_W-1:0] w_data_nxt;
    logic              w_rd_valid_nxt;
    logic [1:0]        w_rd_word_nxt;
    logic              w_ready_nxt;
    logic              w_wr_done_nxt;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_rd_addr;

    // The beat only replaces the low two bits, so a burst never leaves its block.
    assign w_rd_addr = {r_addr_q[ADDR_W-1:2], r_beat};

    // Next-state and next-output decode.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_beat_nxt     = r_beat;
        w_addr_nxt     = r_addr_q;
        w_data_nxt     = r_data_q;
        w_rd_valid_nxt = 1'b0;
        w_rd_word_nxt  = r_rd_word;
        w_ready_nxt    = 1'b0;
        w_wr_done_nxt  = 1'b0;
        w_mem_we       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (main_read) begin
                    w_addr_nxt  = {addr[ADDR_W-1:2], 2'b00};
                    w_cnt_nxt   = {CNT_W{1'b0}};
                    w_state_nxt = ST_RD_WAIT;
                end else if (mem_write) begin
                    w_addr_nxt  = addr;
                    w_data_nxt  = wdata;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                    w_state_nxt = ST_WRITE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                if (r_cnt == CNT_W'(RD_LAT - 1)) begin
                    w_cnt_nxt   = {CNT_W{1'b0}};
                    w_beat_nxt  = 2'd0;
                    w_state_nxt = ST_RD_BURST;
                end else begin
                    w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_RD_BURST: begin
                w_rd_valid_nxt = 1'b1;
                w_rd_word_nxt  = r_beat;
                w_beat_nxt     = r_beat + 2'd1;
                if (r_beat == 2'd3) begin
                    w_state_nxt = ST_RD_DONE;
                end else begin
                    w_state_nxt = ST_RD_BURST;
                end
            end
            ST_RD_DONE: begin
                w_ready_nxt = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            ST_WRITE: begin
                if (r_cnt == CNT_W'(WR_CYCLES - 1)) begin
                    w_mem_we      = 1'b1;
                    w_wr_done_nxt = 1'b1;
                    w_cnt_nxt     = {CNT_W{1'b0}};
                    w_state_nxt   = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Control state and registered outputs; rdata only moves on a valid beat.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= {CNT_W{1'b0}};
            r_beat     <= 2'd0;
            r_addr_q   <= {ADDR_W{1'b0}};
            r_data_q   <= {DATA_W{1'b0}};
            r_rdata    <= {DATA_W{1'b0}};
            r_rd_valid <= 1'b0;
            r_rd_word  <= 2'd0;
            r_ready    <= 1'b0;
            r_wr_done  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_beat     <= w_beat_nxt;
            r_addr_q   <= w_addr_nxt;
            r_data_q   <= w_data_nxt;
            r_rd_valid <= w_rd_valid_nxt;
            r_rd_word  <= w_rd_word_nxt;
            r_ready    <= w_ready_nxt;
            r_wr_done  <= w_wr_done_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
            if (w_rd_valid_nxt) begin
                r_rdata <= r_mem[w_rd_addr];
            end
        end
    end

    // Storage array; deliberately outside reset so contents survive it.
    always_ff @(negedge clk) begin
        if (w_mem_we) begin
            r_mem[r_addr_q] <= r_data_q;
        end
    end

    assign rdata    = r_rdata;
    assign rd_valid = r_rd_valid;
    assign rd_word  = r_rd_word;
    assign ready    = r_ready;
    assign wr_done  = r_wr_done;
    assign busy     = r_busy;

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Randomized self-checking bench for main_memory_ctrl against a word-array
// reference with refill/store timing derived from RD_LAT and WR_CYCLES.
module tb_main_memory_ctrl;

    localparam int RD_LAT    = 2;
    localparam int WR_CYCLES = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        main_read;
    logic        mem_write;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rd_valid;
    logic [1:0]  rd_word;
    logic        ready;
    logic        wr_done;
    logic        busy;

    int errors = 0;
    int checks = 0;

    logic [31:0] model [1024];
    bit          known [1024];

    main_memory_ctrl #(
        .ADDR_W(10), .DATA_W(32), .RD_LAT(RD_LAT), .WR_CYCLES(WR_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .main_read(main_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata), .rdata(rdata), .rd_valid(rd_valid),
        .rd_word(rd_word), .ready(ready), .wr_done(wr_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".busy"},  32'(busy),     32'(1'b0));
        chk({tag, ".ready"}, 32'(ready),    32'(1'b0));
        chk({tag, ".valid"}, 32'(rd_valid), 32'(1'b0));
        chk({tag, ".wrdn"},  32'(wr_done),  32'(1'b0));
    endtask

    task automatic chk_zero(input string tag);
        chk_idle(tag);
        chk({tag, ".rdata"}, rdata,         32'h0);
        chk({tag, ".word"},  32'(rd_word),  32'h0);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            chk_idle("gap");
        end
    endtask

    task automatic release_reset();
        main_read = 1'b0;
        mem_write = 1'b0;
        repeat (2) @(posedge clk);
        chk_zero("in_rst");
        rst = 1'b1;
        @(posedge clk);
        chk_idle("post_rst");
    endtask

    // Store: wr_done expected WR_CYCLES edges after acceptance; abort_k >= 0 resets mid-way.
    task automatic do_write(input logic [9:0] a, input logic [31:0] d, input int abort_k);
        main_read = 1'b0;
        mem_write = 1'b1;
        addr      = a;
        wdata     = d;
        for (int k = 0; k <= WR_CYCLES; k++) begin
            @(posedge clk);
            chk("wr.busy",  32'(busy),     32'(k != WR_CYCLES));
            chk("wr.done",  32'(wr_done),  32'(k == WR_CYCLES));
            chk("wr.ready", 32'(ready),    32'(1'b0));
            chk("wr.valid", 32'(rd_valid), 32'(1'b0));
            if (k == abort_k) begin
                rst = 1'b0;
                #1;
                chk_zero("wr_abort");
                return;
            end
            if (k == 0) begin
                mem_write = 1'b0;
                addr      = 10'($urandom);
                wdata     = $urandom;
            end
        end
        model[a] = d;
        known[a] = 1'b1;
    endtask

    // Refill: beats at edges RD_LAT+1..RD_LAT+4 after acceptance, ready at RD_LAT+5.
    task automatic do_read(input logic [9:0] a, input bit hold_read, input bit wr_sim,
                           input bit wr_hold, input bit disturb, input int abort_k,
                           input logic [31:0] wd);
        logic [9:0] idx;
        int         w;
        main_read = 1'b1;
        addr      = a;
        mem_write = wr_sim;
        wdata     = wd;
        for (int k = 0; k <= RD_LAT + 5; k++) begin
            @(posedge clk);
            w = k - RD_LAT - 1;
            chk("rd.valid", 32'(rd_valid), 32'(w >= 0 && w <= 3));
            chk("rd.ready", 32'(ready),    32'(k == RD_LAT + 5));
            chk("rd.busy",  32'(busy),     32'(k != RD_LAT + 5));
            chk("rd.wrdn",  32'(wr_done),  32'(1'b0));
            if (w >= 0 && w <= 3) begin
                idx = {a[9:2], 2'(w)};
                chk("rd.word", 32'(rd_word), 32'(w));
                if (known[idx]) chk("rd.data", rdata, model[idx]);
            end
            if (k == abort_k) begin
                rst = 1'b0;
                #1;
                chk_zero("rd_abort");
                return;
            end
            if (k == 0) begin
                if (!hold_read) main_read = 1'b0;
                if (!wr_hold) mem_write = 1'b0;
            end
            if (disturb && k == RD_LAT + 1) begin
                addr      = 10'h200;
                mem_write = 1'b1;
                wdata     = $urandom;
            end
            if (disturb && k == RD_LAT + 5) begin
                addr      = a;
                mem_write = 1'b0;
            end
        end
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] old55;
        logic [9:0]  ra;
        rst = 1'b0; main_read = 1'b0; mem_write = 1'b0; addr = 10'h0; wdata = 32'h0;
        for (int i = 0; i < 1024; i++) known[i] = 1'b0;
        #12;
        chk_zero("reset");
        @(posedge clk);
        rst = 1'b1;
        @(posedge clk);
        chk_idle("start");

        for (int i = 0; i < 4; i++) do_write(10'h104 + 10'(i), $urandom, -1);
        do_read(10'h106, 1'b0, 1'b0, 1'b0, 1'b0, -1, 32'h0);

        do_write(10'h3FF, 32'hDEADBEEF, -1);
        do_read(10'h3FC, 1'b0, 1'b0, 1'b0, 1'b0, -1, 32'h0);
        do_read(10'h3FF, 1'b0, 1'b0, 1'b0, 1'b0, -1, 32'h0);

        do_write(10'h010, 32'h0000_1010, -1);
        do_read(10'h010, 1'b0, 1'b1, 1'b0, 1'b0, -1, 32'h5555_AAAA);
        gap(1);
        do_read(10'h010, 1'b0, 1'b0, 1'b0, 1'b0, -1, 32'h0);
        v = $urandom;
        do_read(10'h010, 1'b0, 1'b1, 1'b1, 1'b0, -1, v);
        do_write(10'h010, v, -1);
        do_read(10'h010, 1'b0, 1'b0, 1'b0, 1'b0, -1, 32'h0);

        do_write(10'h200, 32'h0200_0200, -1);
        do_read(10'h105, 1'b0, 1'b0, 1'b0, 1'b1, -1, 32'h0);
        gap(2);
        do_read(10'h200, 1'b0, 1'b0, 1'b0, 1'b0, -1, 32'h0);

        old55 = $urandom;
        do_write(10'h055, old55, -1);
        do_write(10'h055, 32'h0000_1234, 2);
        release_reset();
        do_read(10'h055, 1'b0, 1'b0, 1'b0, 1'b0, -1, 32'h0);
        do_read(10'h104, 1'b0, 1'b0, 1'b0, 1'b0, RD_LAT + 2, 32'h0);
        release_reset();
        gap(3);

        do_read(10'h107, 1'b1, 1'b0, 1'b0, 1'b0, -1, 32'h0);
        do_read(10'h104, 1'b0, 1'b0, 1'b0, 1'b0, -1, 32'h0);
        gap(1);

        for (int n = 0; n < 40; n++) begin
            ra = 10'h100 + 10'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 0) do_write(ra, $urandom, -1);
            else do_read(ra, 1'b0, 1'b0, 1'b0, 1'b0, -1, 32'h0);
            gap($urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
